// File: rtl/video_timing_pkg.sv
// ---------------------------------------------------------------------------
// video_timing_pkg
// Shared definitions for the VGA raster timing generator and its users:
//   - 640x480@60 timing constants (pixel and line counts per region)
//   - sync polarity for that mode
//   - test-pattern select codes
//   - packed RGB pixel type and the colour-bar table
// ---------------------------------------------------------------------------
package video_timing_pkg;

  // 640x480@60, 25.175 MHz pixel clock
  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;
  localparam logic VGA_SYNC_POL = 1'b0;  // both syncs active-low

  // Pattern select codes
  localparam logic [1:0] PAT_EXT   = 2'd0;
  localparam logic [1:0] PAT_BARS  = 2'd1;
  localparam logic [1:0] PAT_CHECK = 2'd2;
  localparam logic [1:0] PAT_GRAD  = 2'd3;

  typedef struct packed {
    logic [7:0] red;
    logic [7:0] green;
    logic [7:0] blue;
  } rgb_t;

  // Colour-bar table, left to right across the active line
  function automatic rgb_t bar_color(input logic [2:0] idx);
    case (idx)
      3'd0:    bar_color = 24'hFFFFFF;  // white
      3'd1:    bar_color = 24'hFFFF00;  // yellow
      3'd2:    bar_color = 24'h00FFFF;  // cyan
      3'd3:    bar_color = 24'h00FF00;  // green
      3'd4:    bar_color = 24'hFF00FF;  // magenta
      3'd5:    bar_color = 24'hFF0000;  // red
      3'd6:    bar_color = 24'h0000FF;  // blue
      default: bar_color = 24'h000000;  // black
    endcase
  endfunction

endpackage

// File: rtl/vga_pattern_gen.sv
// ---------------------------------------------------------------------------
// vga_pattern_gen
// Pixel source mux for the timing generator. Takes the stage-1 coordinate
// and produces the registered (stage-2) RGB value.
//   pclk, resetn : pixel clock, async active-low reset
//   i_x, i_y     : stage-1 pixel coordinate (only y[7:0] is needed)
//   i_active     : stage-1 coordinate lies in the visible area
//   i_pat        : frame-latched pattern select (PAT_*)
//   i_ext        : external pixel, valid during the stage-1 cycle
//   o_rgb        : stage-2 pixel, forced to black outside the visible area
// ---------------------------------------------------------------------------
module vga_pattern_gen
  import video_timing_pkg::*;
#(
  parameter int H_ACTIVE = VGA_H_ACTIVE
) (
  input  logic        pclk,
  input  logic        resetn,
  input  logic [10:0] i_x,
  input  logic [7:0]  i_y,
  input  logic        i_active,
  input  logic [1:0]  i_pat,
  input  rgb_t        i_ext,
  output rgb_t        o_rgb
);

  localparam logic [8:0] BAR_LAST = 9'(H_ACTIVE / 8 - 1);

  // Bar tracking: r_bar_px/r_bar_idx describe the x that follows the one
  // just processed. x advances by one every pclk, so a position counter and
  // a compare against the bar width replace a divide by H_ACTIVE/8.
  logic [8:0] r_bar_px;
  logic [2:0] r_bar_idx;
  logic [8:0] w_bar_px;
  logic [2:0] w_bar_idx;
  logic [7:0] w_sum;
  rgb_t       w_pix;

  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can leave it unassigned and infer a latch.
    w_bar_px  = r_bar_px;
    w_bar_idx = r_bar_idx;
    if (i_x == '0) begin
      w_bar_px  = '0;
      w_bar_idx = '0;
    end
  end

  always_ff @(posedge pclk or negedge resetn) begin
    if (!resetn) begin
      r_bar_px  <= '0;
      r_bar_idx <= '0;
    end else if (w_bar_px == BAR_LAST) begin
      r_bar_px  <= '0;
      r_bar_idx <= w_bar_idx + 3'd1;
    end else begin
      r_bar_px  <= w_bar_px + 9'd1;
      r_bar_idx <= w_bar_idx;
    end
  end

  always_comb begin
    w_sum = i_x[7:0] + i_y;
    w_pix = '0;
    case (i_pat)
      PAT_EXT:   w_pix = i_ext;
      PAT_BARS:  w_pix = bar_color(w_bar_idx);
      PAT_CHECK: w_pix = (i_x[5] ^ i_y[5]) ? '1 : '0;
      default:   w_pix = {i_x[7:0], i_y, w_sum};
    endcase
  end

  always_ff @(posedge pclk or negedge resetn) begin
    if (!resetn) begin
      o_rgb <= '0;
    end else begin
      o_rgb <= i_active ? w_pix : '0;
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// ---------------------------------------------------------------------------
// vga_timing_gen
// Raster timing and test-pattern source for hdmi_device. Three-stage pipe:
//   stage 0: h/v counters, pixel request (out_x/out_y/out_req)
//   stage 1: registered active/sync/coordinate; external RGB arrives here
//   stage 2: output registers (RGB, blank, syncs, frame_start)
// Ports:
//   pclk, resetn        : pixel clock, async active-low reset
//   pattern_sel         : 0 ext, 1 bars, 2 checker, 3 gradient (per frame)
//   out_x/out_y/out_req : stage-0 request to an external pixel source
//   ext_red/green/blue  : external pixel, one pclk after the request
//   out_vga_*           : aligned video to hdmi_device
//   frame_start         : one-pclk pulse with output pixel (0,0)
// ---------------------------------------------------------------------------
module vga_timing_gen
  import video_timing_pkg::*;
#(
  parameter int   H_ACTIVE = VGA_H_ACTIVE,
  parameter int   H_FP     = VGA_H_FP,
  parameter int   H_SYNC   = VGA_H_SYNC,
  parameter int   H_BP     = VGA_H_BP,
  parameter int   V_ACTIVE = VGA_V_ACTIVE,
  parameter int   V_FP     = VGA_V_FP,
  parameter int   V_SYNC   = VGA_V_SYNC,
  parameter int   V_BP     = VGA_V_BP,
  parameter logic SYNC_POL = VGA_SYNC_POL
) (
  input  logic        pclk,
  input  logic        resetn,
  input  logic [1:0]  pattern_sel,
  output logic [10:0] out_x,
  output logic [9:0]  out_y,
  output logic        out_req,
  input  logic [7:0]  ext_red,
  input  logic [7:0]  ext_green,
  input  logic [7:0]  ext_blue,
  output logic [7:0]  out_vga_red,
  output logic [7:0]  out_vga_green,
  output logic [7:0]  out_vga_blue,
  output logic        out_vga_blank,
  output logic        out_vga_hsync,
  output logic        out_vga_vsync,
  output logic        frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  if ((H_ACTIVE % 8) != 0 || H_TOTAL > 2048 || V_TOTAL > 1024) begin : g_bad_timing
    $error("vga_timing_gen: H_ACTIVE must be a multiple of 8 and totals must fit 11/10 bits");
  end

  localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
  localparam logic [10:0] H_ACT    = 11'(H_ACTIVE);
  localparam logic [10:0] H_HS_ON  = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] H_HS_OFF = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0]  V_ACT    = 10'(V_ACTIVE);
  localparam logic [9:0]  V_VS_ON  = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0]  V_VS_OFF = 10'(V_ACTIVE + V_FP + V_SYNC);

  // ---------------- stage 0: counters ----------------
  // r_run holds the counters at (0,0) for the first edge after reset
  // release, so (0,0) is presented as a request before counting starts.
  logic        r_run;
  logic [10:0] r_h;
  logic [9:0]  r_v;
  logic        w_req;
  logic        w_origin;
  logic        w_hs_win;
  logic        w_vs_win;

  always_ff @(posedge pclk or negedge resetn) begin
    if (!resetn) begin
      r_run <= 1'b0;
      r_h   <= '0;
      r_v   <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments, so every register samples pre-edge values.
      r_run <= 1'b1;
      if (r_run) begin
        if (r_h == H_LAST) begin
          r_h <= '0;
          r_v <= (r_v == V_LAST) ? '0 : r_v + 10'd1;
        end else begin
          r_h <= r_h + 11'd1;
        end
      end
    end
  end

  assign w_req    = r_run && (r_h < H_ACT) && (r_v < V_ACT);
  assign w_origin = (r_h == '0) && (r_v == '0);
  assign w_hs_win = (r_h >= H_HS_ON) && (r_h < H_HS_OFF);
  assign w_vs_win = (r_v >= V_VS_ON) && (r_v < V_VS_OFF);

  assign out_x   = r_h;
  assign out_y   = r_v;
  assign out_req = w_req;

  // ---------------- stage 1: decode registers ----------------
  logic        r_s1_active;
  logic        r_s1_hs;
  logic        r_s1_vs;
  logic        r_s1_first;
  logic [10:0] r_s1_x;
  logic [7:0]  r_s1_y;
  logic [1:0]  r_active_pat;

  always_ff @(posedge pclk or negedge resetn) begin
    if (!resetn) begin
      r_s1_active  <= 1'b0;
      r_s1_hs      <= 1'b0;
      r_s1_vs      <= 1'b0;
      r_s1_first   <= 1'b0;
      r_s1_x       <= '0;
      r_s1_y       <= '0;
      r_active_pat <= PAT_EXT;
    end else begin
      r_s1_active <= w_req;
      r_s1_hs     <= w_hs_win;
      r_s1_vs     <= w_vs_win;
      r_s1_first  <= w_req && w_origin;
      r_s1_x      <= r_h;
      r_s1_y      <= r_v[7:0];
      // Pattern changes only take effect at a frame boundary; the new value
      // is visible to stage 1 together with pixel (0,0).
      if (w_origin) r_active_pat <= pattern_sel;
    end
  end

  // ---------------- stage 2: output registers ----------------
  rgb_t w_rgb;

  vga_pattern_gen #(
    .H_ACTIVE (H_ACTIVE)
  ) u_pattern (
    .pclk     (pclk),
    .resetn   (resetn),
    .i_x      (r_s1_x),
    .i_y      (r_s1_y),
    .i_active (r_s1_active),
    .i_pat    (r_active_pat),
    .i_ext    ({ext_red, ext_green, ext_blue}),
    .o_rgb    (w_rgb)
  );

  always_ff @(posedge pclk or negedge resetn) begin
    if (!resetn) begin
      out_vga_blank <= 1'b1;
      out_vga_hsync <= ~SYNC_POL;
      out_vga_vsync <= ~SYNC_POL;
      frame_start   <= 1'b0;
    end else begin
      out_vga_blank <= ~r_s1_active;
      out_vga_hsync <= r_s1_hs ? SYNC_POL : ~SYNC_POL;
      out_vga_vsync <= r_s1_vs ? SYNC_POL : ~SYNC_POL;
      frame_start   <= r_s1_first;
    end
  end

  assign out_vga_red   = w_rgb.red;
  assign out_vga_green = w_rgb.green;
  assign out_vga_blue  = w_rgb.blue;

endmodule

// File: tb/tb_vga_timing_gen.sv
// ---------------------------------------------------------------------------
// tb_vga_timing_gen
// Directed bench for vga_timing_gen on a reduced raster (64x48 visible,
// 96x57 total) so several complete frames fit a short run. Every output
// sample is compared against the raster position it must carry.
// ---------------------------------------------------------------------------
module tb_vga_timing_gen;

  localparam int H_ACT  = 64;
  localparam int H_FP   = 8;
  localparam int H_SY   = 16;
  localparam int H_BP   = 8;
  localparam int V_ACT  = 48;
  localparam int V_FP   = 3;
  localparam int V_SY   = 2;
  localparam int V_BP   = 4;
  localparam int H_TOT  = H_ACT + H_FP + H_SY + H_BP;   // 96
  localparam int V_TOT  = V_ACT + V_FP + V_SY + V_BP;   // 57
  localparam int FRAME  = H_TOT * V_TOT;                // 5472

  localparam logic [1:0] P_EXT = 2'd0, P_BARS = 2'd1, P_CHECK = 2'd2, P_GRAD = 2'd3;

  logic        pclk;
  logic        resetn;
  logic [1:0]  pattern_sel;
  logic [10:0] out_x;
  logic [9:0]  out_y;
  logic        out_req;
  logic [7:0]  ext_red, ext_green, ext_blue;
  logic [7:0]  out_vga_red, out_vga_green, out_vga_blue;
  logic        out_vga_blank, out_vga_hsync, out_vga_vsync, frame_start;

  int n_tests = 0;
  int n_fail  = 0;

  vga_timing_gen #(
    .H_ACTIVE (H_ACT), .H_FP (H_FP), .H_SYNC (H_SY), .H_BP (H_BP),
    .V_ACTIVE (V_ACT), .V_FP (V_FP), .V_SYNC (V_SY), .V_BP (V_BP),
    .SYNC_POL (1'b0)
  ) dut (
    .pclk          (pclk),
    .resetn        (resetn),
    .pattern_sel   (pattern_sel),
    .out_x         (out_x),
    .out_y         (out_y),
    .out_req       (out_req),
    .ext_red       (ext_red),
    .ext_green     (ext_green),
    .ext_blue      (ext_blue),
    .out_vga_red   (out_vga_red),
    .out_vga_green (out_vga_green),
    .out_vga_blue  (out_vga_blue),
    .out_vga_blank (out_vga_blank),
    .out_vga_hsync (out_vga_hsync),
    .out_vga_vsync (out_vga_vsync),
    .frame_start   (frame_start)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // External pixel source: returns {x,y,5A} for the request seen before an
  // edge, valid for the whole following pclk.
  logic [7:0] cap_x, cap_y;
  initial begin
    ext_red = '0; ext_green = '0; ext_blue = '0;
    forever begin
      @(negedge pclk);
      cap_x = out_x[7:0];
      cap_y = out_y[7:0];
      @(posedge pclk);
      #1;
      ext_red   = cap_x;
      ext_green = cap_y;
      ext_blue  = 8'h5A;
    end
  end

  function automatic logic [23:0] exp_pix(input logic [1:0] pat, input int x, input int y);
    logic [7:0] xb, yb;
    xb = 8'(x);
    yb = 8'(y);
    case (pat)
      P_EXT:   exp_pix = {xb, yb, 8'h5A};
      P_BARS:
        case (x / (H_ACT / 8))
          0:       exp_pix = 24'hFFFFFF;
          1:       exp_pix = 24'hFFFF00;
          2:       exp_pix = 24'h00FFFF;
          3:       exp_pix = 24'h00FF00;
          4:       exp_pix = 24'hFF00FF;
          5:       exp_pix = 24'hFF0000;
          6:       exp_pix = 24'h0000FF;
          default: exp_pix = 24'h000000;
        endcase
      P_CHECK: exp_pix = ((((x >> 5) ^ (y >> 5)) & 1) == 1) ? 24'hFFFFFF : 24'h000000;
      default: exp_pix = {xb, yb, 8'(x + y)};
    endcase
  endfunction

  // Counts samples until frame_start is seen (bounded).
  task automatic wait_fs(input string tag, input int exp_cnt);
    int cnt;
    cnt = 0;
    do begin
      @(negedge pclk);
      cnt++;
    end while (!frame_start && cnt < 2 * FRAME);
    check(tag, 32'(cnt), 32'(exp_cnt));
  endtask

  // Entered on the sample carrying output pixel (0,0); walks one full frame
  // and leaves on the (0,0) sample of the next frame.
  task automatic run_frame(input logic [1:0] pat, input logic [1:0] next_sel, input int switch_n);
    int oh, ov, rise_n;
    int blank_err, hs_err, vs_err, rgb_err, hs_low, vs_low, req_cnt, fs_cnt;
    logic act, exp_hs, exp_vs, prev_blank, prev_hs;
    logic [23:0] got_rgb, want_rgb;
    blank_err = 0; hs_err = 0; vs_err = 0; rgb_err = 0;
    hs_low = 0; vs_low = 0; req_cnt = 0; fs_cnt = 0;
    rise_n = -1; prev_blank = 1'b1; prev_hs = 1'b1;
    for (int n = 0; n < FRAME; n++) begin
      if (n > 0) @(negedge pclk);
      oh = n % H_TOT;
      ov = n / H_TOT;
      act    = (oh < H_ACT) && (ov < V_ACT);
      exp_hs = !((oh >= H_ACT + H_FP) && (oh < H_ACT + H_FP + H_SY));
      exp_vs = !((ov >= V_ACT + V_FP) && (ov < V_ACT + V_FP + V_SY));
      got_rgb  = {out_vga_red, out_vga_green, out_vga_blue};
      want_rgb = act ? exp_pix(pat, oh, ov) : 24'h0;
      if (out_vga_blank !== !act)   blank_err++;
      if (out_vga_hsync !== exp_hs) hs_err++;
      if (out_vga_vsync !== exp_vs) vs_err++;
      if (got_rgb !== want_rgb)     rgb_err++;
      if (out_vga_hsync === 1'b0)   hs_low++;
      if (out_vga_vsync === 1'b0)   vs_low++;
      if (out_req === 1'b1)         req_cnt++;
      if (frame_start === 1'b1)     fs_cnt++;
      if (!prev_blank && out_vga_blank) rise_n = n;
      if (prev_hs && !out_vga_hsync && ov == 0) begin
        check("hs_fall_after_line_start", 32'(n), 32'(H_ACT + H_FP));
        check("hs_fall_after_blank_rise", 32'(n - rise_n), 32'(H_FP));
      end
      prev_blank = out_vga_blank;
      prev_hs    = out_vga_hsync;
      if (pat == P_BARS && ov == 0 && oh < H_ACT && (oh % 8) == 0)
        check($sformatf("bar_px%0d", oh), 32'(got_rgb), 32'(exp_pix(P_BARS, oh, 0)));
      if (pat == P_EXT && oh == 10 && ov == 3)
        check("ext_px_10_3", 32'(got_rgb), 32'h0A035A);
      if (pat == P_GRAD && oh == 40 && ov == 36)
        check("grad_px_40_36", 32'(got_rgb), 32'h28244C);
      if (pat == P_CHECK && oh == 32 && ov == 0)
        check("check_px_32_0", 32'(got_rgb), 32'hFFFFFF);
      if (pat == P_CHECK && oh == 32 && ov == 32)
        check("check_px_32_32", 32'(got_rgb), 32'h000000);
      if (n == switch_n) pattern_sel = next_sel;
    end
    check("blank_errors",   32'(blank_err), 32'd0);
    check("hsync_errors",   32'(hs_err),    32'd0);
    check("vsync_errors",   32'(vs_err),    32'd0);
    check("rgb_errors",     32'(rgb_err),   32'd0);
    check("hsync_low_pclk", 32'(hs_low),    32'(H_SY * V_TOT));
    check("vsync_low_pclk", 32'(vs_low),    32'(V_SY * H_TOT));
    check("req_per_frame",  32'(req_cnt),   32'(H_ACT * V_ACT));
    check("fs_per_frame",   32'(fs_cnt),    32'd1);
    @(negedge pclk);
    check("frame_period", 32'(frame_start), 32'd1);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_ctrl"}, 32'({out_vga_blank, out_vga_hsync, out_vga_vsync, frame_start, out_req}),
          32'b11100);
    check({tag, "_rgb"}, 32'({out_vga_red, out_vga_green, out_vga_blue}), 32'h0);
    check({tag, "_xy"}, 32'({out_x, out_y}), 32'h0);
  endtask

  initial begin
    bit found;
    resetn      = 1'b1;
    pattern_sel = P_BARS;
    #3 resetn = 1'b0;
    repeat (3) @(negedge pclk);
    check_reset_values("reset");

    // First (0,0) output two edges after the first post-release edge.
    resetn = 1'b1;
    wait_fs("fs_after_release", 3);

    run_frame(P_BARS,  P_EXT,   FRAME / 2);
    run_frame(P_EXT,   P_GRAD,  FRAME / 2);
    run_frame(P_GRAD,  P_CHECK, 20 * H_TOT);   // mid-frame change, ignored
    run_frame(P_CHECK, P_CHECK, 0);

    // Reset mid-frame at stage-0 position (40,20).
    found = 1'b0;
    for (int i = 0; i < 2 * FRAME && !found; i++) begin
      @(negedge pclk);
      if (out_x == 11'd40 && out_y == 10'd20) found = 1'b1;
    end
    check("reset_point_found", 32'(found), 32'd1);
    check("pre_reset_blank", 32'(out_vga_blank), 32'd0);
    resetn = 1'b0;
    #1;
    check_reset_values("async_reset");
    repeat (3) @(negedge pclk);
    check_reset_values("held_reset");
    resetn = 1'b1;
    wait_fs("fs_after_mid_reset", 3);
    check("post_reset_px00", 32'({out_vga_blank, out_vga_red, out_vga_green, out_vga_blue}), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
